// File: rtl/fpu_issue_if.sv
// Request/response handshake bundle between the instruction sequencer (master)
// and the fpu_issue initiator (slave).
interface fpu_issue_if #(
  parameter int WIDTH     = 32,
  parameter int CMD_WIDTH = 2
);
  logic                 op_valid;
  logic                 op_ready;
  logic [CMD_WIDTH-1:0] op_command;
  logic [WIDTH-1:0]     op_first;
  logic [WIDTH-1:0]     op_second;
  logic                 res_valid;
  logic                 res_ready;
  logic [WIDTH-1:0]     res_data;
  logic                 res_timeout;

  modport master (
    output op_valid, op_command, op_first, op_second, res_ready,
    input  op_ready, res_valid, res_data, res_timeout
  );

  modport slave (
    input  op_valid, op_command, op_first, op_second, res_ready,
    output op_ready, res_valid, res_data, res_timeout
  );
endinterface

// File: rtl/fpu_issue.sv
// Single-op fpu initiator: latches an op, pulses fpu_reset to start the fpu,
// waits for work_is_done (bounded by TIMEOUT) and returns result or timeout.
module fpu_issue #(
  parameter int WIDTH     = 32,
  parameter int CMD_WIDTH = 2,
  parameter int TIMEOUT   = 64
) (
  input  logic                 clock,
  input  logic                 reset,
  fpu_issue_if.slave           bus,
  output logic [CMD_WIDTH-1:0] fpu_command,
  output logic [WIDTH-1:0]     fpu_first,
  output logic [WIDTH-1:0]     fpu_second,
  output logic                 fpu_reset,
  input  logic                 fpu_done,
  input  logic [WIDTH-1:0]     fpu_result,
  output logic [7:0]           timeout_count,
  output logic                 busy
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0]    TIMER_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH-1:0] QNAN       = WIDTH'(32'h7FC0_0000);

  typedef enum logic [1:0] {IDLE, START, WAIT, HOLD} state_t;

  state_t           state, next_state;
  logic [TW-1:0]    timer;
  logic [WIDTH-1:0] res_data_q;
  logic             res_timeout_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:  if (bus.op_valid) next_state = START;
      START: next_state = WAIT;
      WAIT:  if (fpu_done || timer == TIMER_LAST) next_state = HOLD;
      HOLD:  if (bus.res_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      fpu_command   <= '0;
      fpu_first     <= '0;
      fpu_second    <= '0;
      res_data_q    <= '0;
      res_timeout_q <= 1'b0;
      timeout_count <= '0;
      timer         <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.op_valid) begin
            fpu_command <= bus.op_command;
            fpu_first   <= bus.op_first;
            fpu_second  <= bus.op_second;
          end
        end
        START: timer <= '0;
        WAIT: begin
          // done on the final timer cycle still counts as a real result
          if (fpu_done) begin
            res_data_q    <= fpu_result;
            res_timeout_q <= 1'b0;
          end else if (timer == TIMER_LAST) begin
            res_data_q    <= QNAN;
            res_timeout_q <= 1'b1;
            if (timeout_count != 8'hFF) timeout_count <= timeout_count + 8'd1;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign fpu_reset       = reset | (state == START);
  assign bus.op_ready    = (state == IDLE);
  assign bus.res_valid   = (state == HOLD);
  assign bus.res_data    = res_data_q;
  assign bus.res_timeout = res_timeout_q;
  assign busy            = (state != IDLE);

endmodule

// File: tb/tb_fpu_issue.sv
// Randomized bench for fpu_issue: a behavioural fpu answers after a chosen
// delay and a per-op model predicts latency, result and timeout accounting.
module tb_fpu_issue;
  localparam int WIDTH     = 32;
  localparam int CMD_WIDTH = 2;
  localparam int TIMEOUT   = 8;
  localparam logic [31:0] QNAN = 32'h7FC0_0000;

  logic                 clock = 1'b0;
  logic                 reset = 1'b1;
  logic [CMD_WIDTH-1:0] fpu_command;
  logic [WIDTH-1:0]     fpu_first, fpu_second, fpu_result;
  logic                 fpu_reset, fpu_done;
  logic [7:0]           timeout_count;
  logic                 busy;

  fpu_issue_if #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH)) bus ();

  fpu_issue #(.WIDTH(WIDTH), .CMD_WIDTH(CMD_WIDTH), .TIMEOUT(TIMEOUT)) dut (
    .clock(clock), .reset(reset), .bus(bus),
    .fpu_command(fpu_command), .fpu_first(fpu_first), .fpu_second(fpu_second),
    .fpu_reset(fpu_reset), .fpu_done(fpu_done), .fpu_result(fpu_result),
    .timeout_count(timeout_count), .busy(busy)
  );

  always #5 clock = ~clock;

  // Behavioural fpu: cycles counted from the end of its reset pulse; done is
  // raised once the count reaches fpu_delay and held (negative = never).
  int          fpu_delay   = -1;
  int          fpu_cnt     = 0;
  logic        fpu_started = 1'b0;
  logic        force_done  = 1'b0;
  logic [31:0] fpu_value   = '0;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fpu_cnt     <= 0;
      fpu_started <= 1'b0;
    end else if (fpu_reset) begin
      fpu_cnt     <= 0;
      fpu_started <= 1'b1;
    end else if (fpu_cnt < 1000) begin
      fpu_cnt <= fpu_cnt + 1;
    end
  end

  assign fpu_done   = force_done | (fpu_started && fpu_delay >= 0 && fpu_cnt >= fpu_delay);
  assign fpu_result = fpu_value;

  int vectors     = 0;
  int miscompares = 0;
  int model_tcount = 0;

  task automatic check(input string tag, input logic [95:0] got, input logic [95:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // One full op through the request/response channels; delay is the WAIT
  // cycle index at which the fpu first shows done (<0 = never).
  task automatic run_op(input logic [1:0] cmd, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] r, input int delay, input int hold);
    int          cycles;
    int          n;
    int          exp_cycles;
    logic        exp_to;
    logic [31:0] exp_data;
    exp_to     = !(delay >= 0 && delay <= TIMEOUT - 1);
    exp_cycles = exp_to ? TIMEOUT + 1 : delay + 2;
    exp_data   = exp_to ? QNAN : r;
    if (exp_to && model_tcount < 255) model_tcount++;
    fpu_delay = delay;
    fpu_value = r;

    n = 0;
    while (!bus.op_ready && n < 20) begin step(); n++; end
    check("op_ready_before_accept", bus.op_ready, 1'b1);

    bus.op_valid   = 1'b1;
    bus.op_command = cmd;
    bus.op_first   = a;
    bus.op_second  = b;
    step();
    check("start_pulse", fpu_reset, 1'b1);
    check("start_busy", {busy, bus.op_ready}, 2'b10);
    check("start_operands", {fpu_command, fpu_first, fpu_second}, {cmd, a, b});

    cycles = 0;
    while (!bus.res_valid && cycles < TIMEOUT + 6) begin
      bus.op_valid   = 1'($urandom_range(0, 1));
      bus.op_command = 2'($urandom);
      bus.op_first   = $urandom;
      bus.op_second  = $urandom;
      bus.res_ready  = 1'($urandom_range(0, 1));
      step();
      cycles++;
      if (!bus.res_valid) begin
        check("wait_fpu_reset", fpu_reset, 1'b0);
        check("wait_operands", {fpu_command, fpu_first, fpu_second}, {cmd, a, b});
      end
    end
    bus.res_ready = 1'b0;
    check("latency", cycles, exp_cycles);
    check("res_data", bus.res_data, exp_data);
    check("res_timeout", bus.res_timeout, exp_to);
    check("timeout_count", timeout_count, 8'(model_tcount));
    check("hold_op_ready", bus.op_ready, 1'b0);

    for (int h = 0; h < hold; h++) begin
      step();
      check("hold_valid", bus.res_valid, 1'b1);
      check("hold_data", {bus.res_timeout, bus.res_data}, {exp_to, exp_data});
      check("hold_op_ready", bus.op_ready, 1'b0);
    end

    bus.op_valid  = 1'b0;
    bus.res_ready = 1'b1;
    step();
    bus.res_ready = 1'b0;
    check("after_handshake", {bus.op_ready, bus.res_valid, busy}, 3'b100);
    check("retained_operands", {fpu_command, fpu_first, fpu_second}, {cmd, a, b});
  endtask

  initial begin
    bus.op_valid   = 1'b0;
    bus.op_command = '0;
    bus.op_first   = '0;
    bus.op_second  = '0;
    bus.res_ready  = 1'b0;

    // Reset then idle
    #1;
    check("reset_fpu_reset", fpu_reset, 1'b1);
    step();
    step();
    check("reset_fpu_reset_2", fpu_reset, 1'b1);
    reset = 1'b0;
    #1;
    check("idle_fpu_reset", fpu_reset, 1'b0);
    check("idle_flags", {bus.op_ready, bus.res_valid, busy}, 3'b100);
    check("idle_data", {bus.res_timeout, bus.res_data, timeout_count}, '0);
    check("idle_operands", {fpu_command, fpu_first, fpu_second}, '0);

    // Directed cases
    run_op(2'd0, 32'hBF3F_FFFF, 32'hBF3F_FFFF, 32'hBFBF_FFFF, 3, 0);
    run_op(2'd1, 32'h3F80_0000, 32'h4000_0000, 32'h4040_0000, 0, 0);
    run_op(2'd2, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0BAD_F00D, 1, 5);
    run_op(2'd3, 32'h4120_0000, 32'h0000_0000, 32'hFFFF_FFFF, -1, 2);
    run_op(2'd0, 32'h3F00_0000, 32'h3F00_0000, 32'h3F80_0000, 2, 0);
    run_op(2'd1, 32'hC000_0000, 32'h4000_0000, 32'h0000_0000, TIMEOUT - 1, 1);
    run_op(2'd2, 32'h0000_0001, 32'h0000_0002, 32'h0000_0003, TIMEOUT, 0);

    // Randomized ops
    for (int i = 0; i < 40; i++) begin
      int d;
      d = int'($urandom_range(0, TIMEOUT + 2));
      if (d > TIMEOUT - 1) d = -1;
      run_op(2'($urandom), $urandom, $urandom, $urandom, d, int'($urandom_range(0, 3)));
    end

    // Reset two cycles into WAIT, then a late done must not produce a response
    fpu_delay = -1;
    bus.op_valid   = 1'b1;
    bus.op_command = 2'd3;
    bus.op_first   = 32'hAAAA_5555;
    bus.op_second  = 32'h5555_AAAA;
    step();
    bus.op_valid = 1'b0;
    step();
    step();
    step();
    check("pre_reset_busy", busy, 1'b1);
    reset = 1'b1;
    #1;
    model_tcount = 0;
    check("midreset_fpu_reset", fpu_reset, 1'b1);
    check("midreset_flags", {bus.op_ready, bus.res_valid, busy}, 3'b100);
    check("midreset_count", timeout_count, 8'd0);
    step();
    step();
    reset = 1'b0;
    force_done = 1'b1;
    for (int k = 0; k < 5; k++) begin
      step();
      check("late_done_ignored", {bus.op_ready, bus.res_valid, busy, fpu_reset}, 4'b1000);
    end
    force_done = 1'b0;
    run_op(2'd1, 32'h4040_0000, 32'h4080_0000, 32'h40E0_0000, 2, 1);
    run_op(2'd2, 32'h4040_0000, 32'h4080_0000, 32'h0, -1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end
endmodule

// File: doc/fpu_issue.md
Name: fpu_issue

Overview:
Initiator side of the fpu operation interface. Accepts one operation at a time over a valid/ready request channel and drives command and operands into the fpu. Starts the fpu with a one-cycle restart pulse, waits for work_is_done, and returns the result, or a timeout, over a valid/ready response channel. Sits between the instruction sequencer and the fpu, and replaces the hand-driven start/poll sequence previously done in benches.

Parameters:
WIDTH, 32, operand/result width (IEEE-754 single)
CMD_WIDTH, 2, fpu command width
TIMEOUT, 64, max WAIT cycles before abandoning an op (>=2)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; clears all state
op_valid  in  1  request present
op_ready  out  1  request accepted when op_valid&op_ready at rising edge
op_command  in  CMD_WIDTH  fpu command for this op
op_first  in  WIDTH  first operand
op_second  in  WIDTH  second operand
res_valid  out  1  response present
res_ready  in  1  response consumed when res_valid&res_ready at rising edge
res_data  out  WIDTH  fpu result, or 0x7FC00000 on timeout
res_timeout  out  1  response is a timeout, qualified by res_valid
fpu_command  out  CMD_WIDTH  to fpu.command
fpu_first  out  WIDTH  to fpu.first
fpu_second  out  WIDTH  to fpu.second
fpu_reset  out  1  to fpu.reset; start/restart pulse
fpu_done  in  1  from fpu.work_is_done
fpu_result  in  WIDTH  from fpu.result
timeout_count  out  8  saturating count of timed-out ops
busy  out  1  state != IDLE

Behaviour:
- Reset values: state IDLE; all registered outputs 0, including fpu_command/first/second, res_data, res_timeout and timeout_count. fpu_reset = reset | (state==START), combinational, so the fpu is held in reset while this block is.
- FSM states: IDLE, START, WAIT, HOLD. op_ready = (state==IDLE); res_valid = (state==HOLD).
- IDLE:
  - op_valid=1 at an edge latches op_command/op_first/op_second into the fpu_* registers and moves to START.
  - fpu_done is ignored.
- START:
  - Lasts exactly one cycle with fpu_reset=1.
  - Clears the WAIT timer to 0, then moves to WAIT.
- WAIT:
  - fpu_* operand/command outputs are held stable and fpu_reset=0.
  - fpu_done=1 at an edge: res_data<=fpu_result, res_timeout<=0, move to HOLD.
  - Otherwise, if timer==TIMEOUT-1: res_data<=0x7FC00000, res_timeout<=1, timeout_count increments (saturates at 255), move to HOLD.
  - Otherwise the timer increments.
  - Timer width is clog2(TIMEOUT).
- HOLD:
  - res_data and res_timeout are stable.
  - res_ready=1 at an edge moves to IDLE.
  - fpu_done is ignored.
- Latency:
  - Op accepted at edge E0; START during the cycle after E0; WAIT from E1.
  - Earliest result edge is E2, so res_valid rises after E2.
  - Timeout case: res_valid rises after edge E1+TIMEOUT.
- Throughput: one op in flight. After the response handshake, op_ready is high the following cycle; there is no overlap of HOLD and accept.
- fpu_done asserted on the same edge that the timer reaches TIMEOUT-1: done wins (real result, no timeout).
- op_valid while busy is not accepted; the requester holds it.
- Asynchronous reset mid-operation (START/WAIT/HOLD):
  - The in-flight op is dropped and no response is produced.
  - fpu_reset is high during reset.
  - timeout_count returns to 0.
- res_ready while not in HOLD is ignored. The fpu_* outputs retain the last operation after return to IDLE.

Test Plan:
- Reset then idle: reset=1 for 2 cycles -> op_ready=1, res_valid=0, busy=0, fpu_reset=1 during reset and 0 after, all data outputs 0.
- Single add: op_command=0, op_first=op_second=0xBF3FFFFF; fpu model asserts fpu_done with 0xBFBFFFFF 3 cycles after the START pulse -> exactly one fpu_reset pulse, operands stable through WAIT, res_data=0xBFBFFFFF, res_timeout=0.
- Minimum latency: fpu model drives fpu_done=1 constantly after START -> res_valid high after edge E2.
- Response backpressure: hold res_ready=0 for 5 cycles -> res_valid and res_data stable, op_ready=0; assert res_ready -> IDLE next cycle, then a second op is accepted.
- Timeout: TIMEOUT=8 and fpu_done never asserted -> res_valid after E1+8, res_data=0x7FC00000, res_timeout=1, timeout_count=1; a following successful op gives res_timeout=0.
- Reset mid-WAIT: accept op, assert reset 2 cycles into WAIT, then apply a late fpu_done -> no response, state IDLE, op_ready=1; the next op completes normally.
